// File: rtl/addsub_acc_ctrl_pkg.sv
// Shared definitions for the add/subtract accumulator sequencer: state encoding and default widths.
package addsub_acc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/addsub_ov_unit.sv
// Combinational two's-complement add/subtract with sign-bit overflow detection.
module addsub_ov_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] r,
  output logic             v
);

  logic [WIDTH-1:0] w_b_eff;

  // Subtraction as a + ~b + 1; overflow comes from the sign rule, never from negating b,
  // so subtracting the most negative value needs no special case.
  assign w_b_eff = sub ? ~b : b;
  assign r       = a + w_b_eff + WIDTH'(sub);
  assign v       = (a[WIDTH-1] == (b[WIDTH-1] ^ sub)) & (r[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/addsub_acc_ctrl.sv
// Operand-stream accumulator sequencer with sticky overflow and first-overflow index.
// Build option: ADDSUB_ACC_SAT_EN saturates the accumulator on overflowing steps instead of wrapping.
//
// state   | meaning
// IDLE    | waiting for start; outputs hold last job's result/ov/ov_idx
// RUN     | accepting operands, one per cycle, until len have been taken
// DONE    | one-cycle done pulse, results final
module addsub_acc_ctrl
  import addsub_acc_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ov,
  output logic [CNT_W-1:0] ov_idx
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_result;
  logic             r_ov;
  logic [CNT_W-1:0] r_ov_idx;

  logic             w_in_ready;
  logic             w_busy;
  logic             w_done;
  logic             w_xfer;
  logic             w_last;
  logic [WIDTH-1:0] w_sum;
  logic             w_v;
  logic [WIDTH-1:0] w_res_nxt;

  addsub_ov_unit #(.WIDTH(WIDTH)) u_addsub (
    .a   (r_result),
    .b   (in_data),
    .sub (in_sub),
    .r   (w_sum),
    .v   (w_v)
  );

  assign w_xfer = in_valid & w_in_ready;
  assign w_last = (r_count == (r_len - CNT_W'(1)));

`ifdef ADDSUB_ACC_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Overflow direction follows the sign of the accumulator before the step.
  assign w_res_nxt = w_v ? (r_result[WIDTH-1] ? SAT_MIN : SAT_MAX) : w_sum;
`else
  assign w_res_nxt = w_sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = (len != '0) ? ST_RUN : ST_DONE;
      ST_RUN:  if (w_xfer && w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
      end
      ST_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len    <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_ov     <= 1'b0;
      r_ov_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_len    <= len;
          r_count  <= '0;
          r_result <= '0;
          r_ov     <= 1'b0;
          r_ov_idx <= '0;
        end
        ST_RUN: if (w_xfer) begin
          r_result <= w_res_nxt;
          if (w_v && !r_ov) begin
            r_ov     <= 1'b1;
            r_ov_idx <= r_count;
          end
          r_count <= r_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready = w_in_ready;
  assign busy     = w_busy;
  assign done     = w_done;
  assign result   = r_result;
  assign ov       = r_ov;
  assign ov_idx   = r_ov_idx;

endmodule
